// File: rtl/timer_pkg.sv
// Shared encodings for the timer array: mode values and control-register bit layout.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_SQUARE   = 2'd2,
    MODE_FREERUN  = 2'd3
  } mode_e;

  // ctrl[1:0] = mode, ctrl[2] = enable, ctrl[3] = interrupt enable
  localparam int CTRL_EN    = 2;
  localparam int CTRL_IRQEN = 3;
  localparam int CTRL_W     = 4;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: count/reload/ctrl state, tick edge detect, output pin and pending bit.
// Latency: a tick edge or write updates state on that clk edge; visible the following cycle.
// Backpressure: none; writes always accepted and take priority over a same-cycle tick.
// Ports: tick (raw divider bit), we_load/we_ctrl/wdata (decoded write), ack (W1C pending),
//        count/cnt_out/pend/irq_en (state exported to the top for readback and irq).
module timer_chan
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             we_load,
  input  logic             we_ctrl,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             cnt_out,
  output logic             pend,
  output logic             irq_en
);

  logic [WIDTH-1:0]  reload;
  logic [CTRL_W-1:0] ctrl;
  logic              tick_q;

  logic [WIDTH-1:0]  count_n;
  logic [WIDTH-1:0]  reload_n;
  logic [CTRL_W-1:0] ctrl_n;
  logic              cnt_out_n;
  logic              pend_set;

  mode_e mode;
  logic  en;
  logic  tick_rise;

  assign mode      = mode_e'(ctrl[1:0]);
  assign en        = ctrl[CTRL_EN];
  assign irq_en    = ctrl[CTRL_IRQEN];
  assign tick_rise = tick & ~tick_q;

  always_comb begin
    count_n   = count;
    reload_n  = reload;
    ctrl_n    = ctrl;
    cnt_out_n = cnt_out;
    pend_set  = 1'b0;

    // Periodic output is a single-cycle strobe; drop it unless re-raised below.
    if (mode == MODE_PERIODIC) cnt_out_n = 1'b0;

    if (we_load) begin
      reload_n  = wdata;
      count_n   = (mode == MODE_FREERUN) ? '0 : wdata;
      cnt_out_n = 1'b0;
    end else if (we_ctrl) begin
      ctrl_n = wdata[CTRL_W-1:0];
    end else if (en && tick_rise) begin
      case (mode)
        MODE_ONESHOT: begin
          if (count > WIDTH'(1)) begin
            count_n = count - WIDTH'(1);
          end else if (count == WIDTH'(1)) begin
            count_n        = '0;
            pend_set       = 1'b1;
            cnt_out_n      = 1'b1;
            ctrl_n[CTRL_EN] = 1'b0;  // one-shot disarms itself
          end
        end
        MODE_PERIODIC: begin
          if (count > WIDTH'(1)) begin
            count_n = count - WIDTH'(1);
          end else if (count == WIDTH'(1)) begin
            count_n   = reload;
            pend_set  = 1'b1;
            cnt_out_n = 1'b1;
          end
        end
        MODE_SQUARE: begin
          if (count > WIDTH'(1)) begin
            count_n = count - WIDTH'(1);
          end else if (count == WIDTH'(1)) begin
            count_n   = reload;
            cnt_out_n = ~cnt_out;
            pend_set  = cnt_out;  // only the falling half of the square raises pend
          end
        end
        MODE_FREERUN: begin
          count_n   = count + WIDTH'(1);
          pend_set  = &count;
          cnt_out_n = count_n[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      reload  <= '0;
      ctrl    <= '0;
      pend    <= 1'b0;
      cnt_out <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      count   <= count_n;
      reload  <= reload_n;
      ctrl    <= ctrl_n;
      cnt_out <= cnt_out_n;
      tick_q  <= tick;
      // a new event beats a same-cycle acknowledge
      pend    <= pend_set | (pend & ~ack);
    end
  end

endmodule

// File: rtl/timer_array_x.sv
// NCH-channel timer array: write decode, count readback mux and interrupt reduction.
// Latency: writes/ticks take effect on the next clk edge; rdata and irq are combinational from registers.
// Backpressure: none; out-of-range ch_sel writes are dropped, out-of-range rd_ch reads return 0.
// Ports: clk/RSTN, tick[NCH], we/ch_sel/reg_sel/wdata write port, rd_ch/rdata readback,
//        cnt_out[NCH], irq_pend[NCH] (unmasked), int_ack[NCH] (W1C), irq.
module timer_array_x
  import timer_pkg::*;
#(
  parameter  int NCH   = 3,
  parameter  int WIDTH = 32,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic [NCH-1:0]   tick,
  input  logic             we,
  input  logic [CHW-1:0]   ch_sel,
  input  logic             reg_sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic [CHW-1:0]   rd_ch,
  output logic [WIDTH-1:0] rdata,
  output logic [NCH-1:0]   cnt_out,
  output logic [NCH-1:0]   irq_pend,
  input  logic [NCH-1:0]   int_ack,
  output logic             irq
);

  logic [WIDTH-1:0] count_a [NCH];
  logic [NCH-1:0]   irq_en;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic sel;
    assign sel = we && (ch_sel == CHW'(i));

    timer_chan #(.WIDTH(WIDTH)) u_chan (
      .clk     (clk),
      .rst_n   (RSTN),
      .tick    (tick[i]),
      .we_load (sel && !reg_sel),
      .we_ctrl (sel && reg_sel),
      .wdata   (wdata),
      .ack     (int_ack[i]),
      .count   (count_a[i]),
      .cnt_out (cnt_out[i]),
      .pend    (irq_pend[i]),
      .irq_en  (irq_en[i])
    );
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == CHW'(i)) rdata = count_a[i];
    end
  end

  assign irq = |(irq_pend & irq_en);

endmodule

// File: tb/tb_timer_array_x.sv
module tb_timer_array_x;

  logic clk = 1'b0;
  logic RSTN = 1'b0;
  always #5 clk = ~clk;

  // main instance: NCH=3, WIDTH=32
  logic [2:0]  tick3 = '0;
  logic        we3 = 1'b0;
  logic [1:0]  ch_sel3 = '0;
  logic        reg_sel3 = 1'b0;
  logic [31:0] wdata3 = '0;
  logic [1:0]  rd_ch3 = '0;
  logic [31:0] rdata3;
  logic [2:0]  cnt_out3;
  logic [2:0]  irq_pend3;
  logic [2:0]  int_ack3 = '0;
  logic        irq3;

  // second instance: NCH=4, WIDTH=8
  logic [3:0]  tick4 = '0;
  logic        we4 = 1'b0;
  logic [1:0]  ch_sel4 = '0;
  logic        reg_sel4 = 1'b0;
  logic [7:0]  wdata4 = '0;
  logic [1:0]  rd_ch4 = '0;
  logic [7:0]  rdata4;
  logic [3:0]  cnt_out4;
  logic [3:0]  irq_pend4;
  logic [3:0]  int_ack4 = '0;
  logic        irq4;

  int checks = 0;
  int errors = 0;

  timer_array_x #(.NCH(3), .WIDTH(32)) dut (
    .clk(clk), .RSTN(RSTN), .tick(tick3), .we(we3), .ch_sel(ch_sel3),
    .reg_sel(reg_sel3), .wdata(wdata3), .rd_ch(rd_ch3), .rdata(rdata3),
    .cnt_out(cnt_out3), .irq_pend(irq_pend3), .int_ack(int_ack3), .irq(irq3)
  );

  timer_array_x #(.NCH(4), .WIDTH(8)) dut4 (
    .clk(clk), .RSTN(RSTN), .tick(tick4), .we(we4), .ch_sel(ch_sel4),
    .reg_sel(reg_sel4), .wdata(wdata4), .rd_ch(rd_ch4), .rdata(rdata4),
    .cnt_out(cnt_out4), .irq_pend(irq_pend4), .int_ack(int_ack4), .irq(irq4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr3(input logic [1:0] ch, input logic sel, input logic [31:0] d);
    we3 = 1'b1; ch_sel3 = ch; reg_sel3 = sel; wdata3 = d;
    step();
    we3 = 1'b0;
  endtask

  task automatic wr4(input logic [1:0] ch, input logic sel, input logic [7:0] d);
    we4 = 1'b1; ch_sel4 = ch; reg_sel4 = sel; wdata4 = d;
    step();
    we4 = 1'b0;
  endtask

  task automatic pulse3(input int i);
    tick3[i] = 1'b1; step(); tick3[i] = 1'b0; step();
  endtask

  task automatic pulse4(input int i);
    tick4[i] = 1'b1; step(); tick4[i] = 1'b0; step();
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick3 = ~tick3; tick4 = ~tick4;
      step();
    end
    for (int r = 0; r < 3; r++) begin
      rd_ch3 = 2'(r); #1;
      checks++;
      if (rdata3 !== 32'd0) begin errors++; $display("FAIL reset_rdata ch%0d: got %0d want 0", r, rdata3); end
    end
    checks++;
    if (irq3 !== 1'b0 || cnt_out3 !== 3'b000 || irq_pend3 !== 3'b000) begin
      errors++; $display("FAIL reset_outputs: irq=%b cnt_out=%b pend=%b want 0/000/000", irq3, cnt_out3, irq_pend3);
    end
    tick3 = '0; tick4 = '0;
    step();
    RSTN = 1'b1;
    step();
    // loaded but not enabled: ticks must not count
    wr3(2'd0, 1'b0, 32'd5);
    rd_ch3 = 2'd0;
    pulse3(0);
    checks++;
    if (rdata3 !== 32'd5) begin errors++; $display("FAIL reset_no_count: got %0d want 5", rdata3); end
  endtask

  task automatic test_oneshot();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'd2; exp_seq[1] = 32'd1; exp_seq[2] = 32'd0;
    wr3(2'd0, 1'b0, 32'd3);
    wr3(2'd0, 1'b1, 32'hC);
    rd_ch3 = 2'd0;
    for (int k = 0; k < 3; k++) begin
      pulse3(0);
      checks++;
      if (rdata3 !== exp_seq[k]) begin errors++; $display("FAIL oneshot_count edge%0d: got %0d want %0d", k+1, rdata3, exp_seq[k]); end
    end
    checks++;
    if (irq_pend3[0] !== 1'b1 || irq3 !== 1'b1 || cnt_out3[0] !== 1'b1) begin
      errors++; $display("FAIL oneshot_event: pend=%b irq=%b out=%b want 1/1/1", irq_pend3[0], irq3, cnt_out3[0]);
    end
    pulse3(0);
    checks++;
    if (rdata3 !== 32'd0 || cnt_out3[0] !== 1'b1) begin
      errors++; $display("FAIL oneshot_hold: count=%0d out=%b want 0/1", rdata3, cnt_out3[0]);
    end
    int_ack3[0] = 1'b1; step(); int_ack3[0] = 1'b0;
    checks++;
    if (irq3 !== 1'b0 || irq_pend3[0] !== 1'b0) begin
      errors++; $display("FAIL oneshot_ack: irq=%b pend=%b want 0/0", irq3, irq_pend3[0]);
    end
    // hardware cleared en: a fresh load must stay frozen
    wr3(2'd0, 1'b0, 32'd5);
    checks++;
    if (cnt_out3[0] !== 1'b0) begin errors++; $display("FAIL oneshot_load_clr_out: got %b want 0", cnt_out3[0]); end
    pulse3(0);
    checks++;
    if (rdata3 !== 32'd5) begin errors++; $display("FAIL oneshot_en_cleared: got %0d want 5", rdata3); end
  endtask

  task automatic test_periodic();
    logic [31:0] exp_seq [6];
    int events = 0;
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 1;
    exp_seq[3] = 2; exp_seq[4] = 1; exp_seq[5] = 2;
    wr3(2'd1, 1'b0, 32'd2);
    wr3(2'd1, 1'b1, 32'h5);
    rd_ch3 = 2'd1;
    for (int k = 0; k < 6; k++) begin
      tick3[1] = 1'b1; step(); tick3[1] = 1'b0;
      checks++;
      if (rdata3 !== exp_seq[k]) begin errors++; $display("FAIL periodic_count edge%0d: got %0d want %0d", k+1, rdata3, exp_seq[k]); end
      if (exp_seq[k] == 32'd2) begin
        checks++;
        if (cnt_out3[1] !== 1'b1 || irq_pend3[1] !== 1'b1 || irq3 !== 1'b0) begin
          errors++; $display("FAIL periodic_event edge%0d: out=%b pend=%b irq=%b want 1/1/0", k+1, cnt_out3[1], irq_pend3[1], irq3);
        end
        if (irq_pend3[1] === 1'b1) events++;
      end
      step();
      checks++;
      if (cnt_out3[1] !== 1'b0) begin errors++; $display("FAIL periodic_pulse_width edge%0d: out=%b want 0", k+1, cnt_out3[1]); end
      if (irq_pend3[1] === 1'b1) begin
        int_ack3[1] = 1'b1; step(); int_ack3[1] = 1'b0;
      end
    end
    checks++;
    if (events != 3) begin errors++; $display("FAIL periodic_events: got %0d want 3", events); end
  endtask

  task automatic test_square_freerun();
    wr4(2'd2, 1'b0, 8'd4);
    wr4(2'd2, 1'b1, 8'h6);
    for (int k = 0; k < 4; k++) pulse4(2);
    checks++;
    if (cnt_out4[2] !== 1'b1 || irq_pend4[2] !== 1'b0) begin
      errors++; $display("FAIL square_rise: out=%b pend=%b want 1/0", cnt_out4[2], irq_pend4[2]);
    end
    for (int k = 0; k < 4; k++) pulse4(2);
    checks++;
    if (cnt_out4[2] !== 1'b0 || irq_pend4[2] !== 1'b1) begin
      errors++; $display("FAIL square_fall: out=%b pend=%b want 0/1", cnt_out4[2], irq_pend4[2]);
    end
    wr4(2'd3, 1'b1, 8'h7);
    wr4(2'd3, 1'b0, 8'd0);
    rd_ch4 = 2'd3;
    for (int k = 0; k < 255; k++) pulse4(3);
    checks++;
    if (rdata4 !== 8'd255 || cnt_out4[3] !== 1'b1 || irq_pend4[3] !== 1'b0) begin
      errors++; $display("FAIL freerun_255: count=%0d out=%b pend=%b want 255/1/0", rdata4, cnt_out4[3], irq_pend4[3]);
    end
    pulse4(3);
    checks++;
    if (rdata4 !== 8'd0 || cnt_out4[3] !== 1'b0 || irq_pend4[3] !== 1'b1) begin
      errors++; $display("FAIL freerun_wrap: count=%0d out=%b pend=%b want 0/0/1", rdata4, cnt_out4[3], irq_pend4[3]);
    end
  endtask

  task automatic test_collisions();
    wr3(2'd0, 1'b1, 32'h5);
    wr3(2'd0, 1'b0, 32'd10);
    rd_ch3 = 2'd0;
    tick3[0] = 1'b1;
    wr3(2'd0, 1'b0, 32'd7);
    tick3[0] = 1'b0;
    checks++;
    if (rdata3 !== 32'd7) begin errors++; $display("FAIL collide_load_tick: got %0d want 7", rdata3); end
    step();
    pulse3(0);
    checks++;
    if (rdata3 !== 32'd6) begin errors++; $display("FAIL collide_after: got %0d want 6", rdata3); end
    // ch1: reload 2, count 2 from the periodic test
    rd_ch3 = 2'd1;
    pulse3(1);
    tick3[1] = 1'b1; int_ack3[1] = 1'b1;
    step();
    tick3[1] = 1'b0; int_ack3[1] = 1'b0;
    checks++;
    if (irq_pend3[1] !== 1'b1 || rdata3 !== 32'd2) begin
      errors++; $display("FAIL collide_ack_set: pend=%b count=%0d want 1/2", irq_pend3[1], rdata3);
    end
    step();
    int_ack3[1] = 1'b1; step(); int_ack3[1] = 1'b0;
    checks++;
    if (irq_pend3[1] !== 1'b0) begin errors++; $display("FAIL collide_ack_later: pend=%b want 0", irq_pend3[1]); end
  endtask

  task automatic test_mid_reset();
    rd_ch3 = 2'd1;
    pulse3(1);
    checks++;
    if (rdata3 !== 32'd1) begin errors++; $display("FAIL midreset_pre: got %0d want 1", rdata3); end
    #3 RSTN = 1'b0;
    #1;
    checks++;
    if (rdata3 !== 32'd0 || cnt_out3 !== 3'b000 || irq_pend3 !== 3'b000 || irq3 !== 1'b0 ||
        cnt_out4 !== 4'b0000 || irq_pend4 !== 4'b0000) begin
      errors++; $display("FAIL midreset_async: count=%0d out=%b pend=%b irq=%b out4=%b pend4=%b want all 0",
                         rdata3, cnt_out3, irq_pend3, irq3, cnt_out4, irq_pend4);
    end
    step();
    RSTN = 1'b1;
    step();
    pulse3(1);
    checks++;
    if (rdata3 !== 32'd0 || irq_pend3[1] !== 1'b0) begin
      errors++; $display("FAIL midreset_after: count=%0d pend=%b want 0/0", rdata3, irq_pend3[1]);
    end
  endtask

  task automatic test_bounds();
    logic [31:0] exp_rd [3];
    exp_rd[0] = 0; exp_rd[1] = 9; exp_rd[2] = 0;
    wr3(2'd1, 1'b0, 32'd9);
    wr3(2'd3, 1'b0, 32'd55);
    wr3(2'd3, 1'b1, 32'h5);
    tick3 = 3'b111; step(); tick3 = 3'b000; step();
    for (int r = 0; r < 3; r++) begin
      rd_ch3 = 2'(r); #1;
      checks++;
      if (rdata3 !== exp_rd[r]) begin errors++; $display("FAIL bounds_ch%0d: got %0d want %0d", r, rdata3, exp_rd[r]); end
    end
    rd_ch3 = 2'd3; #1;
    checks++;
    if (rdata3 !== 32'd0) begin errors++; $display("FAIL bounds_rd3: got %0d want 0", rdata3); end
    checks++;
    if (cnt_out3 !== 3'b000 || irq_pend3 !== 3'b000) begin
      errors++; $display("FAIL bounds_outputs: out=%b pend=%b want 000/000", cnt_out3, irq_pend3);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_square_freerun();
    test_collisions();
    test_mid_reset();
    test_bounds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
